// File: rtl/aes_out_serializer_pkg.sv
// Shared AES result-path types: job tag, stream geometry and the buffered entry layout.
package aes_out_serializer_pkg;

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    ENCRYPT = 2'd1,
    DECRYPT = 2'd2
  } job_t;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W  = 32;
  localparam int AES_BEATS   = 4;

  typedef struct packed {
    logic [AES_BLOCK_W-1:0] data;
    job_t                   tag;
  } entry_t;

endpackage

// File: rtl/aes_out_serializer_fifo.sv
// Block FIFO for completed AES results; entries are wiped on pop and on clear.
module aes_out_fifo
  import aes_out_serializer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  entry_t                   i_entry,
  input  logic                     i_pop,
  output entry_t                   o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_pop;
  logic w_push;

  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_mem[r_rd_ptr] <= '0;
        r_rd_ptr        <= r_rd_ptr + PW'(1);
      end
      // Write after the pop wipe: when full, the write reuses the slot just freed.
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/aes_out_serializer.sv
// Buffers AES last-round results and drains each 128-bit block as four 32-bit words, MSB first.
module aes_out_serializer
  import aes_out_serializer_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [127:0]           in_data,
  input  job_t                   in_type,
  input  logic                   clear,
  output logic [31:0]            out_word,
  output job_t                   out_type,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(AES_BEATS);

  logic [BW-1:0]   r_beat;
  logic            r_overflow;

  entry_t          w_head;
  entry_t          w_entry;
  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_push_req;
  logic            w_xfer;
  logic            w_pop;
  logic            w_drop;
  logic [31:0]     w_word;

  assign w_push_req = (in_type != INVALID) && !clear;
  assign w_entry    = '{data: in_data, tag: in_type};
  assign w_xfer     = out_valid && out_ready;
  assign w_pop      = w_xfer && (r_beat == BW'(AES_BEATS - 1));
  assign w_drop     = w_push_req && w_full && !w_pop;

  aes_out_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (clear),
    .i_push  (w_push_req),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat     <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_beat     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_xfer) r_beat <= r_beat + BW'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Idle outputs are forced to zero so no stale key-dependent data is visible.
  always_comb begin
    w_word = '0;
    if (out_valid) begin
      case (r_beat)
        2'd0:    w_word = w_head.data[127:96];
        2'd1:    w_word = w_head.data[95:64];
        2'd2:    w_word = w_head.data[63:32];
        default: w_word = w_head.data[31:0];
      endcase
    end
  end

  assign out_valid   = (w_count != '0);
  assign out_word    = w_word;
  assign out_type    = out_valid ? w_head.tag : INVALID;
  assign out_last    = out_valid && (r_beat == BW'(AES_BEATS - 1));
  assign count       = w_count;
  assign almost_full = (w_count >= CW'(DEPTH - AFULL_MARGIN));
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Self-checking bench for aes_out_serializer against a queue-based reference model.
module tb_aes_out_serializer;
  import aes_out_serializer_pkg::*;

  localparam int DEPTH = 4;
  localparam int AFM   = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  job_t         in_type;
  logic         clear;
  logic [31:0]  out_word;
  job_t         out_type;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [2:0]   count;
  logic         almost_full;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  aes_out_serializer #(.DEPTH(DEPTH), .AFULL_MARGIN(AFM)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_type(in_type), .clear(clear),
    .out_word(out_word), .out_type(out_type), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .count(count), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of whole blocks, the index of the next word, and the sticky flag.
  typedef struct { logic [127:0] d; job_t t; } blk_t;
  blk_t       mq[$];
  int         mbeat;
  bit         movf;
  logic [31:0] got[$];

  function automatic void model_reset();
    mq.delete(); mbeat = 0; movf = 0;
  endfunction

  function automatic void model_update();
    bit valid, xfer, pop, push;
    blk_t b;
    valid = mq.size() != 0;
    xfer  = valid && out_ready;
    pop   = xfer && mbeat == 3;
    push  = in_type != INVALID && !clear;
    if (clear) begin
      model_reset();
      return;
    end
    if (xfer) mbeat = (mbeat + 1) % 4;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) begin
        b.d = in_data; b.t = in_type; mq.push_back(b);
      end else movf = 1;
    end
  endfunction

  // {valid, word, type, last, count, almost_full, overflow}
  function automatic logic [40:0] exp_vec();
    logic        v;
    logic [31:0] w;
    logic [1:0]  t;
    logic [127:0] sh;
    v = mq.size() != 0;
    w = '0; t = 2'(INVALID);
    if (v) begin
      sh = mq[0].d >> (32 * (3 - mbeat));
      w  = sh[31:0];
      t  = 2'(mq[0].t);
    end
    return {v, w, t, v && mbeat == 3, 3'(mq.size()), mq.size() >= DEPTH - AFM, movf};
  endfunction

  function automatic logic [40:0] obs_vec();
    return {out_valid, out_word, 2'(out_type), out_last, count, almost_full, overflow};
  endfunction

  task automatic step(input logic [127:0] d, input job_t t, input logic rdy, input logic clr);
    in_data = d; in_type = t; out_ready = rdy; clear = clr;
    if (out_valid && out_ready && !clear) got.push_back(out_word);
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_data = '0; in_type = INVALID; clear = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs_vec() !== 41'd0) begin
      errors++; $display("FAIL reset_state got=%h want=%h", obs_vec(), 41'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_block();
    logic [31:0] w[4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
    step(128'h69c4e0d86a7b0430d8cdb78070b4c55a, ENCRYPT, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_word !== w[i] || out_type !== ENCRYPT || out_valid !== 1'b1 || out_last !== (i == 3)) begin
        errors++;
        $display("FAIL single_word%0d got=%h/%0d/%b/%b want=%h/%0d/1/%b",
                 i, out_word, out_type, out_valid, out_last, w[i], ENCRYPT, i == 3);
      end
      step(rnd128(), INVALID, 1'b1, 1'b0);
    end
    checks++;
    if (count !== 3'd0 || out_word !== 32'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_done got count=%0d word=%h want 0/0", count, out_word);
    end
  endtask

  task automatic test_invalid_interleave();
    got.delete();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) step(128'h00112233445566778899aabbccddeeff, DECRYPT, 1'b1, 1'b0);
      else        step(rnd128(), INVALID, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL interleave_c%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (got.size() != 4 || got[0] !== 32'h00112233 || got[3] !== 32'hccddeeff) begin
      errors++; $display("FAIL interleave_words got n=%0d want n=4", got.size());
    end
  endtask

  task automatic test_backpressure();
    logic rdy[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] w[4] = '{32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d};
    got.delete();
    step(128'hdeadbeef0123456789abcdefcafef00d, ENCRYPT, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step('0, INVALID, rdy[i], 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL backpressure_c%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    step('0, INVALID, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got.size() != 4 || got[i] !== w[i]) begin
        errors++; $display("FAIL backpressure_word%0d got=%h want=%h n=%0d", i,
                           (got.size() > i) ? got[i] : 32'hx, w[i], got.size());
      end
    end
  endtask

  task automatic test_overflow();
    logic [127:0] blk[5];
    for (int i = 0; i < 5; i++) blk[i] = rnd128();
    for (int i = 0; i < 5; i++) begin
      step(blk[i], ENCRYPT, 1'b0, 1'b0);
      checks++;
      if (count !== 3'(i < 4 ? i + 1 : 4) || almost_full !== (i >= 1)) begin
        errors++; $display("FAIL overflow_fill%0d got count=%0d af=%b want %0d/%b",
                           i, count, almost_full, (i < 4 ? i + 1 : 4), i >= 1);
      end
    end
    step('0, INVALID, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_flag got=%b want=1", overflow);
    end
    got.delete();
    for (int i = 0; i < 16; i++) step('0, INVALID, 1'b1, 1'b0);
    checks++;
    if (got.size() != 16 || got[12] !== blk[3][127:96] || got[15] !== blk[3][31:0]
        || count !== 3'd0 || overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_drain got n=%0d count=%0d ovf=%b want 16/0/1",
                         got.size(), count, overflow);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) step(rnd128(), DECRYPT, 1'b0, 1'b0);
    step('0, INVALID, 1'b1, 1'b0);
    step('0, INVALID, 1'b1, 1'b0);
    step(rnd128(), ENCRYPT, 1'b1, 1'b1);
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || out_word !== 32'd0
        || out_type !== INVALID) begin
      errors++; $display("FAIL clear_state got count=%0d vld=%b ovf=%b word=%h want 0/0/0/0",
                         count, out_valid, overflow, out_word);
    end
    step(128'hffeeddccbbaa99887766554433221100, ENCRYPT, 1'b1, 1'b0);
    checks++;
    if (out_word !== 32'hffeeddcc || count !== 3'd1 || out_last !== 1'b0) begin
      errors++; $display("FAIL clear_restart got=%h cnt=%0d want ffeeddcc/1", out_word, count);
    end
    for (int i = 0; i < 4; i++) step('0, INVALID, 1'b1, 1'b0);
  endtask

  task automatic test_overflow_pop();
    for (int i = 0; i < 4; i++) step(rnd128(), ENCRYPT, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step('0, INVALID, 1'b1, 1'b0);
    checks++;
    if (out_last !== 1'b1 || count !== 3'd4) begin
      errors++; $display("FAIL ovfpop_setup got last=%b count=%0d want 1/4", out_last, count);
    end
    step(rnd128(), DECRYPT, 1'b1, 1'b0);
    checks++;
    if (overflow !== 1'b0 || count !== 3'd4 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL ovfpop_state got=%h want=%h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 16; i++) begin
      step('0, INVALID, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL ovfpop_drain%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    step(rnd128(), ENCRYPT, 1'b1, 1'b0);
    step(rnd128(), DECRYPT, 1'b1, 1'b0);
    in_type = INVALID;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 41'd0) begin
      errors++; $display("FAIL async_reset got=%h want=%h", obs_vec(), 41'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(128'h0f0e0d0c0b0a09080706050403020100, DECRYPT, 1'b1, 1'b0);
    checks++;
    if (out_word !== 32'h0f0e0d0c || out_type !== DECRYPT || count !== 3'd1) begin
      errors++; $display("FAIL async_restart got=%h/%0d/%0d want 0f0e0d0c/2/1", out_word, out_type, count);
    end
    for (int i = 0; i < 4; i++) step('0, INVALID, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    job_t t;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0: t = INVALID;
        1: t = ENCRYPT;
        default: t = DECRYPT;
      endcase
      step(rnd128(), t, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 59) == 0));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_c%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_invalid_interleave();
    test_backpressure();
    test_overflow();
    test_clear();
    test_overflow_pop();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_out_serializer.md
Name: aes_out_serializer

Overview:
- Sits directly downstream of the AES last-round stage and consumes its registered (128-bit block, job_t) pair every cycle.
- Discards INVALID slots and buffers completed ENCRYPT/DECRYPT blocks in a small FIFO.
- Drains each block to the host as four 32-bit words over a valid/ready stream.
- Raises almost_full back to the issue logic, because the round pipeline cannot stall.

Parameters:
- DEPTH, 4: block entries in the FIFO; power of two, at least 2.
- AFULL_MARGIN, 2: free entries still remaining when almost_full asserts; covers blocks already in flight.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- in_data  in  128  result block from the last-round stage
- in_type  in  job_t  INVALID / ENCRYPT / DECRYPT tag for in_data
- clear  in  1  synchronous flush and zeroize
- out_word  out  32  current output word
- out_type  out  job_t  tag of the block being drained
- out_valid  out  1  out_word is valid
- out_ready  in  1  host accepts out_word
- out_last  out  1  marks the 4th word of a block
- count  out  $clog2(DEPTH)+1  occupied entries, including a partially drained one
- almost_full  out  1  count >= DEPTH-AFULL_MARGIN
- overflow  out  1  sticky: a valid block was dropped

Behaviour:
- Reset, rst_n low (asynchronous, active-low, clock clk):
  - FIFO emptied and storage zeroed.
  - beat=0; out_valid=0, out_word=0, out_type=INVALID, out_last=0, count=0, almost_full=0, overflow=0.
- Push:
  - A push occurs in any cycle where in_type!=INVALID and clear=0.
  - Entry stored is {in_data, in_type}.
  - An INVALID input is never stored.
- Full drop:
  - If the FIFO is full and no pop occurs that cycle, the push is dropped.
  - overflow sets on the next edge and stays set until clear or reset.
- Simultaneous push and pop when full:
  - The pop frees a slot, so the push is accepted.
  - count is unchanged; overflow is not set.
- Drain:
  - out_valid = (count!=0).
  - Head block is sent MSB first: beat 0 = [127:96], beat 1 = [95:64], beat 2 = [63:32], beat 3 = [31:0].
  - out_type = head tag, held for all 4 beats.
  - out_last = out_valid && beat==3.
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - Each transfer advances beat, wrapping 3 to 0.
  - While out_valid && !out_ready, out_word, out_type and out_last are held stable.
  - out_ready while out_valid=0 has no effect.
- Pop:
  - A pop occurs on the beat-3 transfer.
  - The head entry is zeroed in the same edge and the read pointer advances.
  - Back-to-back blocks drain at 1 word per cycle with no bubble.
- Latency: a block pushed into an empty FIFO presents beat 0 on out_word in the cycle after the push edge (1-cycle latency).
- Security: out_word=0 and out_type=INVALID whenever out_valid=0; stale key-dependent data never appears on idle outputs.
- clear (synchronous, priority over push and pop):
  - Empties the FIFO, zeroes all entries, sets beat=0 and overflow=0.
  - The input presented in the same cycle is dropped.
  - clear applied mid-block abandons the remaining beats.
- Counter behaviour:
  - count is updated as +1 (push only), -1 (pop only), 0 (both or neither).
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- almost_full is registered-equivalent, derived combinationally from the registered count.
- Reset asserted mid-block: everything returns to reset values immediately; no partial block survives.

Decomposition:
- job_t (INVALID, ENCRYPT, DECRYPT) stays in the shared sysdef.svh package.
- Add to that package: AES_WORD_W=32 and AES_BEATS=4.
- Sub-module aes_out_fifo: storage, pointers, count, zeroize-on-pop and zeroize-on-clear.
- Top level holds the beat counter, output mux, handshake and overflow flag.

Test Plan:
- Single ENCRYPT block 69c4e0d86a7b0430d8cdb78070b4c55a with out_ready=1 -> words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a on 4 consecutive cycles; out_type=ENCRYPT; out_last only on the 4th word; count returns to 0.
- INVALID inputs for 10 cycles interleaved with one DECRYPT block 00112233445566778899aabbccddeeff -> exactly 4 words drained, tag DECRYPT; out_word=0 while idle.
- Backpressure: out_ready toggled 1,0,0,1 during a block -> each word held stable while ready=0; no word lost or duplicated.
- Overflow:
  - out_ready=0, push 5 valid blocks at DEPTH=4 -> count=4, almost_full asserted from count 2, overflow=1, 5th block absent from the drain.
  - Same fill, with the 5th push on the same cycle as the beat-3 pop -> no overflow.
- clear after 2 of 4 beats with 3 blocks queued -> next cycle count=0, out_valid=0, overflow=0; internal entries read as zero.
- rst_n asserted asynchronously mid-drain -> outputs reach reset values without waiting for a clock edge; after release a new block drains from beat 0.
